// File: rtl/key_sub_counter_pkg.sv
// Shared widths, limits and debounce state encoding for the key-driven digit counter.
package key_sub_counter_pkg;

    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 8;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } deb_state_e;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low push-button.
// Emits a single registered pulse per accepted press.
module key_debounce
    import key_sub_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_n_i,
    output logic press_pulse_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             sync1_q;
    logic             sync2_q;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             armed_q;
    logic             armed_d;
    logic             pulse_q;
    logic             pulse_d;

    // Two-flop synchronizer, reset to the released level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next-state logic; until armed, a key must read released for the full window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        pulse_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (!armed_q) begin
                    // Both sync stages must be high so reset values alone cannot arm the key.
                    if (sync1_q && sync2_q) begin
                        if (cnt_q == CNT_LAST) begin
                            armed_d = 1'b1;
                            cnt_d   = CNT_ZERO;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d = CNT_ZERO;
                    end
                end else if (!sync2_q) begin
                    state_d = PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            PRESS_CHK: begin
                if (sync2_q) begin
                    state_d = RELEASED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ZERO;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (sync2_q) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            RELEASE_CHK: begin
                if (!sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Debounce state, counter, arm flag and press pulse registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RELEASED;
            cnt_q   <= CNT_ZERO;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
        end
    end

    assign press_pulse_o = pulse_q;

endmodule

// File: rtl/key_sub_counter.sv
// Down-counting digit driven by a debounced subtract key and a reload key.
// Flags zero and pulses borrow when a subtract wraps from 0 to MAX_VAL.
module key_sub_counter
    import key_sub_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int INIT_VAL        = 8,
    parameter int MAX_VAL         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_sub_n,
    input  logic               key_load_n,
    output logic [DIGIT_W-1:0] q,
    output logic               zero,
    output logic               borrow
);

    localparam logic [DIGIT_W-1:0] INIT_Q = DIGIT_W'(INIT_VAL);
    localparam logic [DIGIT_W-1:0] MAX_Q  = DIGIT_W'(MAX_VAL);
    localparam logic [DIGIT_W-1:0] ZERO_Q = {DIGIT_W{1'b0}};
    localparam logic [DIGIT_W-1:0] ONE_Q  = DIGIT_W'(1);

    logic               sub_pulse_s;
    logic               load_pulse_s;
    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;
    logic               zero_q;
    logic               zero_d;
    logic               borrow_q;
    logic               borrow_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_sub (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .key_n_i      (key_sub_n),
        .press_pulse_o(sub_pulse_s)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_load (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .key_n_i      (key_load_n),
        .press_pulse_o(load_pulse_s)
    );

    // Counter update: reload beats subtract; out-of-range values recover to MAX_VAL.
    always_comb begin
        q_d      = q_q;
        borrow_d = 1'b0;
        if (load_pulse_s) begin
            q_d = INIT_Q;
        end else if (sub_pulse_s) begin
            if (q_q > MAX_Q) begin
                q_d = MAX_Q;
            end else if (q_q == ZERO_Q) begin
                q_d      = MAX_Q;
                borrow_d = 1'b1;
            end else begin
                q_d = q_q - ONE_Q;
            end
        end else begin
            q_d = q_q;
        end
        zero_d = (q_d == ZERO_Q);
    end

    // Output registers, kept aligned with each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q      <= INIT_Q;
            zero_q   <= (INIT_Q == ZERO_Q);
            borrow_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            zero_q   <= zero_d;
            borrow_q <= borrow_d;
        end
    end

    assign q      = q_q;
    assign zero   = zero_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_key_sub_counter.sv
// Self-checking bench for key_sub_counter: vector table, hand sequences and random keys
// compared every cycle against a run-length reference model.
module tb_key_sub_counter;

    localparam int DC   = 4;
    localparam int INIT = 8;
    localparam int MAXV = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_sub_n = 1'b1;
    logic       key_load_n = 1'b1;
    logic [3:0] q;
    logic       zero;
    logic       borrow;

    int tests = 0;
    int errors = 0;
    int borrow_seen = 0;

    // Reference model: index 0 = subtract key, 1 = load key
    int m_s1[2], m_s2[2], m_lvl[2], m_zrun[2], m_orun[2], m_arun[2], m_armed[2], m_pulse[2];
    int m_q, m_b;

    typedef struct {
        int sub_len;
        int load_len;
        int exp_q;
        int exp_zero;
        int exp_borrows;
    } vec_t;
    vec_t vecs[$];

    key_sub_counter #(
        .DEBOUNCE_CYCLES(DC),
        .INIT_VAL       (INIT),
        .MAX_VAL        (MAXV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_sub_n (key_sub_n),
        .key_load_n(key_load_n),
        .q         (q),
        .zero      (zero),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_s1[k] = 1; m_s2[k] = 1; m_lvl[k] = 1;
            m_zrun[k] = 0; m_orun[k] = 0; m_arun[k] = 0;
            m_armed[k] = 0; m_pulse[k] = 0;
        end
        m_q = INIT;
        m_b = 0;
    endfunction

    // A key level is accepted once DC consecutive synchronized samples agree.
    function automatic void model_key(input int k, input int raw);
        int samp, samp1;
        samp  = m_s2[k];
        samp1 = m_s1[k];
        m_s2[k] = m_s1[k];
        m_s1[k] = raw;
        m_pulse[k] = 0;
        if (m_armed[k] == 0) begin
            m_arun[k] = (samp != 0 && samp1 != 0) ? m_arun[k] + 1 : 0;
            if (m_arun[k] == DC) m_armed[k] = 1;
            m_zrun[k] = 0;
            m_orun[k] = 0;
        end else begin
            if (samp == 0) begin m_zrun[k]++; m_orun[k] = 0; end
            else begin m_orun[k]++; m_zrun[k] = 0; end
            if (m_lvl[k] == 1 && m_zrun[k] == DC) begin
                m_lvl[k] = 0;
                m_pulse[k] = 1;
            end else if (m_lvl[k] == 0 && m_orun[k] == DC) begin
                m_lvl[k] = 1;
            end
        end
    endfunction

    function automatic void model_edge(input int sub_raw, input int load_raw);
        m_b = 0;
        if (m_pulse[1] != 0) begin
            m_q = INIT;
        end else if (m_pulse[0] != 0) begin
            if (m_q == 0) begin m_q = MAXV; m_b = 1; end
            else m_q = m_q - 1;
        end
        model_key(0, sub_raw);
        model_key(1, load_raw);
    endfunction

    // Called at a negedge; drives inputs, advances one clock, checks, returns at next negedge.
    task automatic step(input int s, input int l);
        int exp_v, act_v;
        key_sub_n  = (s != 0);
        key_load_n = (l != 0);
        @(posedge clk);
        model_edge(s != 0 ? 1 : 0, l != 0 ? 1 : 0);
        #1;
        exp_v = (m_q << 2) | ((m_q == 0) ? 2 : 0) | m_b;
        act_v = int'({q, zero, borrow});
        check("cycle {q,zero,borrow}", act_v, exp_v);
        if (borrow) borrow_seen++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset q", int'(q), 8);
        check("reset zero", int'(zero), 0);
        check("reset borrow", int'(borrow), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1);
    endtask

    initial begin
        int lat;
        int sub_lvl, ld_lvl, sub_left, ld_left;

        model_reset();
        @(negedge clk);
        apply_reset();
        idle(6);

        // Single press held 10 cycles: q changes on the 7th edge after the first low sample
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            step(0, 1);
            if (lat < 0 && q != 4'd8) lat = i;
        end
        idle(8);
        check("press latency edges", lat, 7);
        check("single press q", int'(q), 7);

        // Vector table, starting from a fresh reset at q = 8
        vecs.push_back('{2, 0, 8, 0, 0});   // glitch rejected
        vecs.push_back('{3, 0, 8, 0, 0});   // one sample short
        vecs.push_back('{4, 0, 7, 0, 0});   // exactly DC samples
        vecs.push_back('{6, 0, 6, 0, 0});
        vecs.push_back('{6, 0, 5, 0, 0});
        vecs.push_back('{6, 0, 4, 0, 0});
        vecs.push_back('{6, 0, 3, 0, 0});
        vecs.push_back('{6, 6, 8, 0, 0});   // simultaneous load + sub at q = 3
        vecs.push_back('{6, 0, 7, 0, 0});   // later sub
        vecs.push_back('{0, 6, 8, 0, 0});   // load alone
        for (int v = 7; v >= 0; v--) vecs.push_back('{6, 0, v, (v == 0) ? 1 : 0, 0});
        vecs.push_back('{6, 0, 8, 0, 1});   // wrap 0 -> 8 with one borrow

        apply_reset();
        idle(6);
        foreach (vecs[i]) begin
            int len;
            len = (vecs[i].sub_len > vecs[i].load_len) ? vecs[i].sub_len : vecs[i].load_len;
            borrow_seen = 0;
            for (int c = 0; c < len; c++)
                step(c < vecs[i].sub_len ? 0 : 1, c < vecs[i].load_len ? 0 : 1);
            idle(8);
            check($sformatf("vec%0d q", i), int'(q), vecs[i].exp_q);
            check($sformatf("vec%0d zero", i), int'(zero), vecs[i].exp_zero);
            check($sformatf("vec%0d borrow cycles", i), borrow_seen, vecs[i].exp_borrows);
        end

        // Bounce: alternate for 6 cycles, then steady low -> one decrement
        apply_reset();
        idle(6);
        for (int c = 0; c < 6; c++) step(c % 2, 1);
        for (int c = 0; c < 6; c++) step(0, 1);
        idle(8);
        check("bounce q", int'(q), 7);

        // Reset while the subtract key is held in its press check
        for (int c = 0; c < 4; c++) step(0, 1);
        apply_reset();
        for (int c = 0; c < 20; c++) step(0, 1);
        check("held after reset q", int'(q), 8);
        idle(6);
        for (int c = 0; c < 6; c++) step(0, 1);
        idle(8);
        check("re-press after reset q", int'(q), 7);

        // Random key activity with occasional resets
        sub_lvl = 1; ld_lvl = 1; sub_left = 5; ld_left = 30;
        for (int c = 0; c < 4000; c++) begin
            if (sub_left <= 0) begin
                sub_lvl  = 1 - sub_lvl;
                sub_left = (sub_lvl != 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 9));
            end
            if (ld_left <= 0) begin
                ld_lvl  = 1 - ld_lvl;
                ld_left = (ld_lvl != 0) ? int'($urandom_range(10, 60)) : int'($urandom_range(1, 8));
            end
            if ($urandom_range(0, 599) == 0) apply_reset();
            step(sub_lvl, ld_lvl);
            sub_left--;
            ld_left--;
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
